// File: rtl/dram_arb.sv
// Two-master (A: core data bus, B: DMA bridge) round-robin front end for the Tawas data RAM with lane steering and load alignment.
// Latency: grant is combinational in the request cycle; the response (rvalid/rdata/err) follows exactly one cycle later, fully pipelined.
// Backpressure: requesters hold req with stable fields until gnt; responses cannot be stalled.
module dram_arb #(
  parameter int ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [31:0] a_addr,
  input  logic [1:0]  a_size,
  input  logic        a_signed,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [31:0] b_addr,
  input  logic [1:0]  b_size,
  input  logic        b_signed,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] dram_addr,
  output logic        dram_cs,
  output logic        dram_wr,
  output logic [3:0]  dram_mask,
  output logic [31:0] dram_din,
  input  logic [31:0] dram_dout
);

  typedef struct packed {
    logic       port;    // 0 = A, 1 = B
    logic [1:0] offset;
    logic [1:0] size;
    logic       sgn;
    logic       wr;
    logic       err;
  } pend_t;

  logic        last_b;
  logic        sel_b;
  logic        req_any;
  logic        g_wr;
  logic        g_sgn;
  logic        g_err;
  logic [1:0]  g_size;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [31:0] g_din;
  logic [3:0]  g_mask;
  logic [31:0] last_addr_q;
  logic [31:0] last_din_q;
  pend_t       pend_q;
  logic        pend_vld;
  logic [31:0] rd_sh;
  logic [31:0] rd_ext;
  logic [31:0] rsp_dat;

  // B wins only when A is idle or A won the previous grant.
  always_comb begin
    sel_b   = b_req & (~a_req | ~last_b);
    req_any = (a_req | b_req) & rst_n;
    a_gnt   = req_any & ~sel_b;
    b_gnt   = req_any & sel_b;
    g_wr    = sel_b ? b_wr     : a_wr;
    g_addr  = sel_b ? b_addr   : a_addr;
    g_size  = sel_b ? b_size   : a_size;
    g_sgn   = sel_b ? b_signed : a_signed;
    g_wdata = sel_b ? b_wdata  : a_wdata;
    g_err   = (g_size == 2'b11) |
              ((g_size == 2'b01) & g_addr[0]) |
              ((g_size == 2'b10) & (|g_addr[1:0])) |
              (|(g_addr >> ADDR_BITS));
    case (g_size)
      2'b00:   begin g_mask = 4'b0001 << g_addr[1:0];            g_din = {4{g_wdata[7:0]}};  end
      2'b01:   begin g_mask = g_addr[1] ? 4'b1100 : 4'b0011;     g_din = {2{g_wdata[15:0]}}; end
      default: begin g_mask = 4'b1111;                           g_din = g_wdata;            end
    endcase
    dram_cs   = req_any & ~g_err;
    dram_wr   = dram_cs & g_wr;
    dram_mask = dram_wr ? g_mask : 4'b0000;
    dram_addr = req_any ? g_addr : last_addr_q;
    dram_din  = req_any ? g_din  : last_din_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b      <= 1'b1;
      pend_vld    <= 1'b0;
      pend_q      <= '0;
      last_addr_q <= '0;
      last_din_q  <= '0;
    end else begin
      pend_vld <= req_any;
      if (req_any) begin
        last_b      <= sel_b;
        pend_q      <= '{port: sel_b, offset: g_addr[1:0], size: g_size,
                         sgn: g_sgn, wr: g_wr, err: g_err};
        last_addr_q <= g_addr;
        last_din_q  <= g_din;
      end
    end
  end

  // RAM data arrives the cycle after the grant; shift the addressed lane down and extend.
  always_comb begin
    rd_sh = dram_dout >> {pend_q.offset, 3'b000};
    case (pend_q.size)
      2'b00:   rd_ext = {{24{pend_q.sgn & rd_sh[7]}},  rd_sh[7:0]};
      2'b01:   rd_ext = {{16{pend_q.sgn & rd_sh[15]}}, rd_sh[15:0]};
      default: rd_ext = rd_sh;
    endcase
    rsp_dat  = (pend_q.wr | pend_q.err) ? 32'h0 : rd_ext;
    a_rvalid = pend_vld & ~pend_q.port;
    b_rvalid = pend_vld & pend_q.port;
    a_rdata  = a_rvalid ? rsp_dat : 32'h0;
    b_rdata  = b_rvalid ? rsp_dat : 32'h0;
    a_err    = a_rvalid & pend_q.err;
    b_err    = b_rvalid & pend_q.err;
  end

endmodule

// File: tb/tb_dram_arb.sv
// Directed bench for dram_arb: byte-level reference memory, per-port response scoreboard, word RAM model.
// Latency: responses are expected on the exact cycle after each grant.
// Backpressure: requests are held by the bench until the expected grant cycle.
module tb_dram_arb;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_wr, a_signed, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_size;
  logic        b_req, b_wr, b_signed, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_size;
  logic [31:0] dram_addr, dram_din, dram_dout;
  logic        dram_cs, dram_wr;
  logic [3:0]  dram_mask;

  dram_arb #(.ADDR_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_size(a_size), .a_signed(a_signed),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_size(b_size), .b_signed(b_signed),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .dram_addr(dram_addr), .dram_cs(dram_cs), .dram_wr(dram_wr), .dram_mask(dram_mask),
    .dram_din(dram_din), .dram_dout(dram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t qa[$];
  rsp_t qb[$];

  logic [7:0]  ref_mem [int];
  logic [31:0] ram     [int];

  always @(posedge clk) cyc++;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // RAM model: control captured mid-cycle, acted on at the clock edge.
  logic        s_cs, s_wr;
  logic [31:0] s_addr, s_din, ram_w;
  logic [3:0]  s_mask;
  int          ram_idx;
  always @(negedge clk) begin
    s_cs = dram_cs; s_wr = dram_wr; s_addr = dram_addr; s_din = dram_din; s_mask = dram_mask;
  end
  always @(posedge clk) begin
    if (s_cs) begin
      ram_idx = int'(s_addr[15:2]);
      if (s_wr) begin
        ram_w = ram.exists(ram_idx) ? ram[ram_idx] : 32'h0;
        for (int l = 0; l < 4; l++)
          if (s_mask[l]) ram_w[8*l +: 8] = s_din[8*l +: 8];
        ram[ram_idx] = ram_w;
      end else begin
        dram_dout <= ram.exists(ram_idx) ? ram[ram_idx] : 32'h0;
      end
    end
  end

  // Response monitor: every cycle each port must show rvalid exactly when a response is due.
  always @(negedge clk) begin
    if (mon_en) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        chk1("a_rvalid", a_rvalid, 1'b1);
        chk32("a_rdata", a_rdata, qa[0].rdata);
        chk1("a_err", a_err, qa[0].err);
        void'(qa.pop_front());
      end else begin
        chk1("a_rvalid_idle", a_rvalid, 1'b0);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        chk1("b_rvalid", b_rvalid, 1'b1);
        chk32("b_rdata", b_rdata, qb[0].rdata);
        chk1("b_err", b_err, qb[0].err);
        void'(qb.pop_front());
      end else begin
        chk1("b_rvalid_idle", b_rvalid, 1'b0);
      end
    end
  end

  task automatic set_a(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] wd);
    a_req = 1'b1; a_wr = wr; a_addr = addr; a_size = sz; a_signed = sgn; a_wdata = wd;
  endtask

  task automatic set_b(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] wd);
    b_req = 1'b1; b_wr = wr; b_addr = addr; b_size = sz; b_signed = sgn; b_wdata = wd;
  endtask

  // Checks the RAM-side view of one grant against the reference model and queues its response.
  task automatic expect_access(input logic port, input logic wr, input logic [31:0] addr,
                               input logic [1:0] sz, input logic sgn, input logic [31:0] wd,
                               input bit push);
    rsp_t        r;
    logic        err;
    logic [31:0] v;
    logic [31:0] din;
    logic [3:0]  m;
    int          nb;
    int          base;
    err  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) ||
           (addr >= 32'h0001_0000);
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(addr[15:0]);
    v    = 32'h0;
    chk1("dram_cs", dram_cs, !err);
    if (err) begin
      chk1("dram_wr_err", dram_wr, 1'b0);
      chk32("dram_mask_err", {28'h0, dram_mask}, 32'h0);
    end else begin
      chk1("dram_wr", dram_wr, wr);
      chk32("dram_addr", dram_addr, addr);
      if (wr) begin
        m = 4'b0000;
        for (int k = 0; k < nb; k++) begin
          m[int'(addr[1:0]) + k] = 1'b1;
          ref_mem[base + k] = wd[8*k +: 8];
        end
        din = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
        chk32("dram_mask", {28'h0, dram_mask}, {28'h0, m});
        chk32("dram_din", dram_din, din);
      end else begin
        for (int k = 0; k < nb; k++)
          v[8*k +: 8] = ref_mem.exists(base + k) ? ref_mem[base + k] : 8'h00;
        if (sgn && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      end
    end
    r.due   = cyc + 1;
    r.rdata = (wr || err) ? 32'h0 : v;
    r.err   = err;
    if (push) begin
      if (port) qb.push_back(r);
      else      qa.push_back(r);
    end
  endtask

  // Called at drive time (posedge+1); returns at the next drive time.
  task automatic tick(input logic exp_ga, input logic exp_gb, input bit push);
    #3;
    chk1("a_gnt", a_gnt, exp_ga);
    chk1("b_gnt", b_gnt, exp_gb);
    if (exp_ga)
      expect_access(1'b0, a_wr, a_addr, a_size, a_signed, a_wdata, push);
    else if (exp_gb)
      expect_access(1'b1, b_wr, b_addr, b_size, b_signed, b_wdata, push);
    else begin
      chk1("dram_cs_idle", dram_cs, 1'b0);
      chk32("dram_mask_idle", {28'h0, dram_mask}, 32'h0);
    end
    @(posedge clk);
    #1;
    if (exp_ga) a_req = 1'b0;
    if (exp_gb) b_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_a_gnt"}, a_gnt, 1'b0);
    chk1({tag, "_b_gnt"}, b_gnt, 1'b0);
    chk1({tag, "_a_rvalid"}, a_rvalid, 1'b0);
    chk1({tag, "_b_rvalid"}, b_rvalid, 1'b0);
    chk32({tag, "_a_rdata"}, a_rdata, 32'h0);
    chk32({tag, "_b_rdata"}, b_rdata, 32'h0);
    chk1({tag, "_a_err"}, a_err, 1'b0);
    chk1({tag, "_b_err"}, b_err, 1'b0);
    chk1({tag, "_dram_cs"}, dram_cs, 1'b0);
    chk1({tag, "_dram_wr"}, dram_wr, 1'b0);
    chk32({tag, "_dram_mask"}, {28'h0, dram_mask}, 32'h0);
    chk32({tag, "_dram_addr"}, dram_addr, 32'h0);
    chk32({tag, "_dram_din"}, dram_din, 32'h0);
  endtask

  initial begin
    rst_n = 1'b1;
    dram_dout = 32'h0;
    a_req = 0; a_wr = 0; a_addr = 0; a_size = 0; a_signed = 0; a_wdata = 0;
    b_req = 0; b_wr = 0; b_addr = 0; b_size = 0; b_signed = 0; b_wdata = 0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    mon_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Word store then signed byte loads of every lane (read right after write).
    set_a(1'b1, 32'h10, 2'd2, 1'b0, 32'h8000_12F0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_a(1'b0, 32'h10 + i, 2'd0, 1'b1, 32'h0);
      tick(1'b1, 1'b0, 1'b1);
    end

    // Upper-half store from B and unsigned reload.
    set_b(1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_BEEF);
    tick(1'b0, 1'b1, 1'b1);
    set_b(1'b0, 32'h22, 2'd1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1);

    // Both ports contend every cycle: strict alternation starting with A.
    for (int i = 0; i < 6; i++) begin
      if (!a_req) set_a(1'b0, 32'h10 + 32'(i % 4), 2'd0, 1'(i % 2), 32'h0);
      if (!b_req) set_b(1'b0, 32'h22, 2'd1, 1'(i % 3 == 1), 32'h0);
      tick(i % 2 == 0, i % 2 == 1, 1'b1);
    end

    // Error cases: misaligned word, out of window, illegal size, misaligned half store.
    set_a(1'b0, 32'h6, 2'd2, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b1);
    set_a(1'b0, 32'h0001_0000, 2'd2, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b1);
    set_b(1'b0, 32'h0, 2'd3, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1);
    set_b(1'b1, 32'h23, 2'd1, 1'b0, 32'h0000_1234);
    tick(1'b0, 1'b1, 1'b1);
    set_b(1'b0, 32'h22, 2'd1, 1'b1, 32'h0);
    tick(1'b0, 1'b1, 1'b1);

    // Back-to-back word loads after filling the first four words.
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, 32'(4 * i), 2'd2, 1'b0, 32'hA5A5_0000 + 32'(i * 32'h1111));
      tick(1'b1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      set_a(1'b0, 32'(4 * i), 2'd2, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b1);
    end
    tick(1'b0, 1'b0, 1'b1);

    // Reset lands while a store response is pending: it must be dropped.
    set_a(1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFE_F00D);
    ref_mem[32'h40] = 8'h0D; ref_mem[32'h41] = 8'hF0;
    ref_mem[32'h42] = 8'hFE; ref_mem[32'h43] = 8'hCA;
    tick(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    set_a(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
    set_b(1'b0, 32'h42, 2'd1, 1'b1, 32'h0);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    chk32("qa_drained", 32'(qa.size()), 32'h0);
    chk32("qb_drained", 32'(qb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
